// File: rtl/c432_lock_pkg.sv
// Shared widths, state encoding and helpers for the c432 key-locking loader.
package c432_lock_pkg;

  localparam int unsigned KEY_X_W    = 10;
  localparam int unsigned KEY_P_W    = 4;
  localparam int unsigned FRAME_W    = 15;
  localparam int unsigned FAIL_CNT_W = 4;
  localparam int unsigned BEAT_CNT_W = 4;
  localparam int unsigned TIMER_W    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StArmed,
    StFail,
    StLockout
  } state_e;

  // Saturating increment so the failure count never wraps back to a small value.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/c432_key_frame_sr.sv
// LSB-first frame shift register with beat counter and running parity.
module c432_key_frame_sr
  import c432_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               shift_bit,
  output logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               last_beat,
  output logic               parity_ok
);

  logic [FRAME_W-1:0]    frame_q;
  logic [BEAT_CNT_W-1:0] cnt_q;
  logic                  par_q;

  // clr wins over shift so a beat coincident with a restart is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else if (clr) begin
      frame_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else if (shift && !done) begin
      frame_q <= {shift_bit, frame_q[FRAME_W-1:1]};
      cnt_q   <= cnt_q + 4'd1;
      par_q   <= par_q ^ shift_bit;
    end
  end

  assign frame     = frame_q;
  assign done      = (cnt_q == 4'(FRAME_W));
  assign last_beat = (cnt_q == 4'(FRAME_W - 1));
  assign parity_ok = ~par_q;

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: receives, parity-checks and
// applies the 14-bit key, with sticky lockout after repeated bad frames.
module c432_key_loader
  import c432_lock_pkg::*;
#(
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  key_in_valid,
  input  logic                  key_in_bit,
  output logic                  key_in_ready,
  output logic [KEY_X_W-1:0]    key_x,
  output logic [KEY_P_W-1:0]    key_p,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  load_err,
  output logic [FAIL_CNT_W-1:0] fail_cnt,
  output logic                  lockout
);

  localparam logic [TIMER_W-1:0]    TimeoutVal = TIMER_W'(TIMEOUT);
  localparam logic [FAIL_CNT_W-1:0] MaxFailVal = FAIL_CNT_W'(MAX_FAIL);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [KEY_X_W-1:0]    key_x_q, key_x_d;
  logic [KEY_P_W-1:0]    key_p_q, key_p_d;
  logic                  key_valid_q, key_valid_d;

  logic                  sr_clr, sr_shift;
  logic [FRAME_W-1:0]    sr_frame;
  logic                  sr_done, sr_last_beat, sr_parity_ok;
  logic                  beat;
  logic [FAIL_CNT_W-1:0] fail_cnt_inc;
  logic                  unused_parity_bit;

  c432_key_frame_sr u_frame_sr (
    .clk       (clk),
    .rst       (rst),
    .clr       (sr_clr),
    .shift     (sr_shift),
    .shift_bit (key_in_bit),
    .frame     (sr_frame),
    .done      (sr_done),
    .last_beat (sr_last_beat),
    .parity_ok (sr_parity_ok)
  );

  // The parity bit is consumed through the running parity, not read back.
  assign unused_parity_bit = sr_frame[FRAME_W-1];

  assign beat         = key_in_valid && (state_q == StLoad);
  assign fail_cnt_inc = sat_inc(fail_cnt_q);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fail_cnt_d  = fail_cnt_q;
    key_x_d     = key_x_q;
    key_p_d     = key_p_q;
    key_valid_d = key_valid_q;
    sr_clr      = 1'b0;
    sr_shift    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          sr_clr  = 1'b1;
          timer_d = '0;
        end
      end
      StLoad: begin
        if (load_start) begin
          sr_clr  = 1'b1;
          timer_d = '0;
        end else if (beat) begin
          sr_shift = !sr_done;
          timer_d  = '0;
          if (sr_last_beat) begin
            state_d = StCheck;
          end
        end else if (timer_q + 8'd1 == TimeoutVal) begin
          state_d = StFail;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StCheck: begin
        if (sr_parity_ok) begin
          state_d     = StArmed;
          key_x_d     = sr_frame[KEY_X_W-1:0];
          key_p_d     = sr_frame[KEY_X_W+KEY_P_W-1:KEY_X_W];
          key_valid_d = 1'b1;
        end else begin
          state_d = StFail;
        end
      end
      StArmed: begin
        // Drop the old key before loading so no stale key is presented.
        if (load_start) begin
          state_d     = StLoad;
          key_x_d     = '0;
          key_p_d     = '0;
          key_valid_d = 1'b0;
          sr_clr      = 1'b1;
          timer_d     = '0;
        end
      end
      StFail: begin
        fail_cnt_d = fail_cnt_inc;
        state_d    = (fail_cnt_inc == MaxFailVal) ? StLockout : StIdle;
      end
      StLockout: begin
        state_d = StLockout;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      fail_cnt_q  <= '0;
      key_x_q     <= '0;
      key_p_q     <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      fail_cnt_q  <= fail_cnt_d;
      key_x_q     <= key_x_d;
      key_p_q     <= key_p_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_in_ready = (state_q == StLoad);
  assign busy         = (state_q == StLoad) || (state_q == StCheck);
  assign load_err     = (state_q == StFail);
  assign lockout      = (state_q == StLockout);
  assign key_x        = key_x_q;
  assign key_p        = key_p_q;
  assign key_valid    = key_valid_q;
  assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader: good/bad frames, timeout, lockout,
// re-key, async reset and restart-with-coincident-beat.
module tb_c432_key_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       key_in_valid = 1'b0;
  logic       key_in_bit = 1'b0;
  logic       key_in_ready;
  logic [9:0] key_x;
  logic [3:0] key_p;
  logic       key_valid;
  logic       busy;
  logic       load_err;
  logic [3:0] fail_cnt;
  logic       lockout;

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;

  c432_key_loader #(
    .MAX_FAIL (3),
    .TIMEOUT  (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .key_in_valid (key_in_valid),
    .key_in_bit   (key_in_bit),
    .key_in_ready (key_in_ready),
    .key_x        (key_x),
    .key_p        (key_p),
    .key_valid    (key_valid),
    .busy         (busy),
    .load_err     (load_err),
    .fail_cnt     (fail_cnt),
    .lockout      (lockout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_err === 1'b1) err_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_start = 1'b0;
    key_in_valid = 1'b0;
    key_in_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_beats(input logic [14:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      key_in_valid = 1'b1;
      key_in_bit = f[i];
      @(negedge clk);
    end
    key_in_valid = 1'b0;
    key_in_bit = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({key_x, key_p, key_valid, key_in_ready, busy, load_err, fail_cnt, lockout} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_x, key_p, key_valid, key_in_ready, busy, load_err, fail_cnt, lockout});
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int e0;
    do_reset();
    e0 = err_pulses;
    start_frame();
    n_checks++;
    if ({busy, key_in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL good_load_state: got busy/ready %b expected 11", {busy, key_in_ready});
    end
    send_beats(15'h12A5, 15);
    n_checks++;
    if ({key_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL good_check_cycle: got valid/busy %b expected 01", {key_valid, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({key_valid, key_x, key_p} !== {1'b1, 10'h2A5, 4'h4}) begin
      n_fail++;
      $display("FAIL good_key: got %b %h %h expected 1 2a5 4", key_valid, key_x, key_p);
    end
    n_checks++;
    if ({busy, fail_cnt, err_pulses - e0} !== {1'b0, 4'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL good_no_err: got busy %b fail_cnt %0d pulses %0d expected 0 0 0",
               busy, fail_cnt, err_pulses - e0);
    end
  endtask

  task automatic test_bad_parity();
    int e0;
    do_reset();
    e0 = err_pulses;
    start_frame();
    send_beats(15'h52A5, 15);
    @(negedge clk);
    n_checks++;
    if ({load_err, fail_cnt} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL bad_err_pulse: got err %b cnt %0d expected 1 0", load_err, fail_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({load_err, fail_cnt, key_x, key_valid, busy, key_in_ready} !== {1'b0, 4'd1, 10'h0, 3'b000})
    begin
      n_fail++;
      $display("FAIL bad_after: got err %b cnt %0d x %h valid %b busy %b ready %b expected 0 1 0 0 0 0",
               load_err, fail_cnt, key_x, key_valid, busy, key_in_ready);
    end
    n_checks++;
    if (err_pulses - e0 !== 1) begin
      n_fail++;
      $display("FAIL bad_pulse_count: got %0d expected 1", err_pulses - e0);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    start_frame();
    send_beats(15'h12A5, 5);
    n = 0;
    while (load_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles expected 64", n);
    end
    n_checks++;
    if (key_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_ready: got %b expected 0", key_in_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({fail_cnt, busy} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_count: got cnt %0d busy %b expected 1 0", fail_cnt, busy);
    end
  endtask

  task automatic test_lockout();
    int e0;
    do_reset();
    e0 = err_pulses;
    for (int i = 0; i < 3; i++) begin
      start_frame();
      send_beats(15'h52A5, 15);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({lockout, fail_cnt} !== {(i == 2), 4'(i + 1)}) begin
        n_fail++;
        $display("FAIL lockout_step%0d: got lock %b cnt %0d expected %b %0d",
                 i, lockout, fail_cnt, (i == 2), i + 1);
      end
    end
    n_checks++;
    if (err_pulses - e0 !== 3) begin
      n_fail++;
      $display("FAIL lockout_pulses: got %0d expected 3", err_pulses - e0);
    end
    start_frame();
    n_checks++;
    if ({key_in_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL lockout_ready: got ready/busy %b expected 00", {key_in_ready, busy});
    end
    send_beats(15'h12A5, 15);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({key_valid, key_x, key_p, lockout, fail_cnt} !== {1'b0, 10'h0, 4'h0, 1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL lockout_ignore: got valid %b x %h p %h lock %b cnt %0d expected 0 0 0 1 3",
               key_valid, key_x, key_p, lockout, fail_cnt);
    end
  endtask

  task automatic test_rekey();
    do_reset();
    start_frame();
    send_beats(15'h12A5, 15);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    n_checks++;
    if ({key_valid, key_x, key_p, key_in_ready} !== {1'b0, 10'h0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL rekey_clear: got valid %b x %h p %h ready %b expected 0 0 0 1",
               key_valid, key_x, key_p, key_in_ready);
    end
    // 14'h0155 has five ones, so its even-parity bit is 1.
    send_beats(15'h4155, 15);
    @(negedge clk);
    n_checks++;
    if ({key_valid, key_x, key_p} !== {1'b1, 10'h155, 4'h0}) begin
      n_fail++;
      $display("FAIL rekey_new: got %b %h %h expected 1 155 0", key_valid, key_x, key_p);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_frame();
    send_beats(15'h12A5, 7);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_load: got busy %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, key_in_ready, key_valid, load_err, lockout} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_mid_load: got %b expected 00000",
               {busy, key_in_ready, key_valid, load_err, lockout});
    end
    @(negedge clk);
    rst = 1'b0;
    start_frame();
    send_beats(15'h12A5, 15);
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_armed: got valid %b expected 1", key_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({key_valid, key_x, key_p, busy, fail_cnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_mid_armed: got valid %b x %h p %h busy %b cnt %0d expected all 0",
               key_valid, key_x, key_p, busy, fail_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_restart_drop();
    int e0;
    do_reset();
    e0 = err_pulses;
    start_frame();
    // Three beats with odd parity, so leftover parity would corrupt the next frame.
    send_beats(15'h0001, 3);
    load_start = 1'b1;
    key_in_valid = 1'b1;
    key_in_bit = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    key_in_valid = 1'b0;
    key_in_bit = 1'b0;
    send_beats(15'h12A5, 15);
    n_checks++;
    if ({busy, key_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_check: got busy/valid %b expected 10", {busy, key_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({key_valid, key_x, key_p, err_pulses - e0} !== {1'b1, 10'h2A5, 4'h4, 32'd0}) begin
      n_fail++;
      $display("FAIL restart_key: got %b %h %h pulses %0d expected 1 2a5 4 0",
               key_valid, key_x, key_p, err_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_timeout();
    test_lockout();
    test_rekey();
    test_async_reset();
    test_restart_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
